led_pattern_gen: RTL and testbench



---
 rtl/led_pkg.sv | 21 ++
 rtl/led_channel.sv | 124 ++++++++++++
 rtl/led_pattern_gen.sv | 103 ++++++++++
 tb/tb_led_pattern_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern generator: configuration modes and
// per-channel pattern FSM states.
`timescale 1ns/1ps
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    S_OFF = 3'd0,
    S_ON  = 3'd1,
    S_HI  = 3'd2,
    S_LO  = 3'd3,
    S_GAP = 3'd4
  } ch_state_e;

endpackage

// File: rtl/led_channel.sv
// One LED channel: OFF/ON/BLINK/BURST pattern FSM advanced by the base tick.
// Registered LED output; an apply strobe restarts the pattern and overrides that tick's advance.
`timescale 1ns/1ps
module led_channel
  import led_pkg::*;
#(
  parameter int HW         = 16,
  parameter int CW         = 4,
  parameter int GAP_HALVES = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          tick_i,
  input  logic          apply_i,
  input  mode_e         mode_i,
  input  logic [HW-1:0] half_i,
  input  logic [CW-1:0] count_i,
  output logic          led_o
);

  localparam int GW = $clog2(GAP_HALVES + 1);

  ch_state_e     state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic [HW-1:0] tcnt_q, tcnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          burst_q, burst_d;
  logic          led_q, led_d;
  logic          half_done;

  assign half_done = (tcnt_q == half_q - HW'(1));

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    tcnt_d  = tcnt_q;
    count_d = count_q;
    pcnt_d  = pcnt_q;
    gcnt_d  = gcnt_q;
    burst_d = burst_q;
    if (apply_i) begin
      half_d  = (half_i == '0) ? HW'(1) : half_i;
      count_d = count_i;
      burst_d = (mode_i == MODE_BURST);
      tcnt_d  = '0;
      pcnt_d  = '0;
      gcnt_d  = '0;
      case (mode_i)
        MODE_ON:    state_d = S_ON;
        MODE_BLINK: state_d = S_HI;
        MODE_BURST: state_d = (count_i == '0) ? S_OFF : S_HI;
        default:    state_d = S_OFF;
      endcase
    end else if (tick_i) begin
      case (state_q)
        S_HI: begin
          if (half_done) begin
            tcnt_d  = '0;
            state_d = S_LO;
          end else begin
            tcnt_d = tcnt_q + HW'(1);
          end
        end
        S_LO: begin
          if (half_done) begin
            tcnt_d = '0;
            if (!burst_q) begin
              state_d = S_HI;
            end else begin
              pcnt_d  = pcnt_q + CW'(1);
              state_d = (pcnt_q + CW'(1) == count_q) ? S_GAP : S_HI;
            end
          end else begin
            tcnt_d = tcnt_q + HW'(1);
          end
        end
        S_GAP: begin
          // Gap is counted as GAP_HALVES whole half-periods.
          if (half_done) begin
            tcnt_d = '0;
            if (gcnt_q == GW'(GAP_HALVES - 1)) begin
              gcnt_d  = '0;
              pcnt_d  = '0;
              state_d = S_HI;
            end else begin
              gcnt_d = gcnt_q + GW'(1);
            end
          end else begin
            tcnt_d = tcnt_q + HW'(1);
          end
        end
        default: ;
      endcase
    end
    led_d = (state_d == S_ON) || (state_d == S_HI);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_OFF;
      half_q  <= HW'(1);
      tcnt_q  <= '0;
      count_q <= '0;
      pcnt_q  <= '0;
      gcnt_q  <= '0;
      burst_q <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      tcnt_q  <= tcnt_d;
      count_q <= count_d;
      pcnt_q  <= pcnt_d;
      gcnt_q  <= gcnt_d;
      burst_q <= burst_d;
      led_q   <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern driver: prescaler base tick, staged config port, per-channel FSMs.
// One write staged at a time (CFG_READY low while pending); applied on the next tick edge.
`timescale 1ns/1ps
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int CLK_HZ     = 10_000_000,
  parameter int TICK_HZ    = 1_000,
  parameter int N_CH       = 4,
  parameter int HW         = 16,
  parameter int CW         = 4,
  parameter int GAP_HALVES = 4,
  // One code beyond the last channel so out-of-range writes can be expressed and dropped.
  parameter int CH_W       = $clog2(N_CH + 1)
) (
  input  logic            CLK,
  input  logic            RESETN,
  input  logic            CFG_VALID,
  output logic            CFG_READY,
  input  logic [CH_W-1:0] CFG_CH,
  input  logic [1:0]      CFG_MODE,
  input  logic [HW-1:0]   CFG_HALF,
  input  logic [CW-1:0]   CFG_COUNT,
  output logic            TICK,
  output logic [N_CH-1:0] LED
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = $clog2(TICK_DIV);

  logic [PW-1:0]   pre_q, pre_d;
  logic            tick_q, tick_d;
  logic            pend_q, pend_d;
  logic [CH_W-1:0] stg_ch_q, stg_ch_d;
  mode_e           stg_mode_q, stg_mode_d;
  logic [HW-1:0]   stg_half_q, stg_half_d;
  logic [CW-1:0]   stg_cnt_q, stg_cnt_d;
  logic            accept, apply;

  assign accept = CFG_VALID && !pend_q;
  assign apply  = pend_q && tick_q;

  always_comb begin
    pre_d      = (pre_q == PW'(TICK_DIV - 1)) ? '0 : pre_q + PW'(1);
    tick_d     = (pre_q == PW'(TICK_DIV - 1));
    pend_d     = pend_q;
    stg_ch_d   = stg_ch_q;
    stg_mode_d = stg_mode_q;
    stg_half_d = stg_half_q;
    stg_cnt_d  = stg_cnt_q;
    if (accept) begin
      pend_d     = 1'b1;
      stg_ch_d   = CFG_CH;
      stg_mode_d = mode_e'(CFG_MODE);
      stg_half_d = CFG_HALF;
      stg_cnt_d  = CFG_COUNT;
    end else if (apply) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pre_q      <= '0;
      tick_q     <= 1'b0;
      pend_q     <= 1'b0;
      stg_ch_q   <= '0;
      stg_mode_q <= MODE_OFF;
      stg_half_q <= '0;
      stg_cnt_q  <= '0;
    end else begin
      pre_q      <= pre_d;
      tick_q     <= tick_d;
      pend_q     <= pend_d;
      stg_ch_q   <= stg_ch_d;
      stg_mode_q <= stg_mode_d;
      stg_half_q <= stg_half_d;
      stg_cnt_q  <= stg_cnt_d;
    end
  end

  assign CFG_READY = !pend_q;
  assign TICK      = tick_q;

  // A channel number >= N_CH matches no instance, so the write is silently dropped.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_channel #(
      .HW         (HW),
      .CW         (CW),
      .GAP_HALVES (GAP_HALVES)
    ) u_ch (
      .clk_i   (CLK),
      .rst_ni  (RESETN),
      .tick_i  (tick_q),
      .apply_i (apply && (stg_ch_q == CH_W'(i))),
      .mode_i  (stg_mode_q),
      .half_i  (stg_half_q),
      .count_i (stg_cnt_q),
      .led_o   (LED[i])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with TICK_DIV=10, four channels, GAP_HALVES=4.
`timescale 1ns/1ps
module tb_led_pattern_gen;

  localparam int N_CH = 4;
  localparam int HW   = 16;
  localparam int CW   = 4;
  localparam int CH_W = 3;

  logic            CLK       = 1'b0;
  logic            RESETN    = 1'b0;
  logic            CFG_VALID = 1'b0;
  logic            CFG_READY;
  logic [CH_W-1:0] CFG_CH    = '0;
  logic [1:0]      CFG_MODE  = '0;
  logic [HW-1:0]   CFG_HALF  = '0;
  logic [CW-1:0]   CFG_COUNT = '0;
  logic            TICK;
  logic [N_CH-1:0] LED;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  led_pattern_gen #(
    .CLK_HZ(1000), .TICK_HZ(100), .N_CH(N_CH), .HW(HW), .CW(CW), .GAP_HALVES(4), .CH_W(CH_W)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
    .CFG_CH(CFG_CH), .CFG_MODE(CFG_MODE), .CFG_HALF(CFG_HALF), .CFG_COUNT(CFG_COUNT),
    .TICK(TICK), .LED(LED)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge RESETN)
    if (!RESETN) cyc <= 0;
    else         cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic cfg_write(input logic [CH_W-1:0] ch, input logic [1:0] mode,
                           input logic [HW-1:0] half, input logic [CW-1:0] cnt);
    int n;
    n = 0;
    @(negedge CLK);
    CFG_VALID = 1'b1; CFG_CH = ch; CFG_MODE = mode; CFG_HALF = half; CFG_COUNT = cnt;
    while (!CFG_READY && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (!CFG_READY) begin
      n_cmp++; n_err++;
      $display("FAIL cfg_write_timeout ready=%b required=1", CFG_READY);
    end
    @(posedge CLK); #1;
    CFG_VALID = 1'b0;
  endtask

  // Returns just after the next clock edge on which TICK was high.
  task automatic next_tick_edge();
    logic was;
    int   n;
    n = 0;
    do begin
      was = TICK;
      @(posedge CLK); #1;
      n++;
    end while (!was && n < 25);
    if (!was) begin
      n_cmp++; n_err++;
      $display("FAIL tick_timeout tick=%b required=1", TICK);
    end
  endtask

  task automatic test_reset();
    logic exp;
    RESETN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++; if (LED !== 4'b0000) begin n_err++; $display("FAIL reset_led got=%b exp=0000", LED); end
    n_cmp++; if (CFG_READY !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", CFG_READY); end
    n_cmp++; if (TICK !== 1'b0) begin n_err++; $display("FAIL reset_tick got=%b exp=0", TICK); end
    @(negedge CLK);
    RESETN = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      @(posedge CLK); #1;
      exp = (c % 10 == 0);
      n_cmp++;
      if (TICK !== exp) begin n_err++; $display("FAIL tick_cycle%0d got=%b exp=%b", c, TICK, exp); end
    end
  endtask

  task automatic test_blink();
    logic [3:0] exp;
    cfg_write(3'd0, 2'd2, 16'd3, 4'd0);
    for (int k = 0; k < 12; k++) begin
      next_tick_edge();
      exp = 4'b0000;
      exp[0] = ((k / 3) % 2 == 0);
      n_cmp++;
      if (LED !== exp) begin n_err++; $display("FAIL blink_tick%0d got=%b exp=%b", k, LED, exp); end
    end
    cfg_write(3'd0, 2'd0, 16'd0, 4'd0);
    next_tick_edge();
    n_cmp++; if (LED !== 4'b0000) begin n_err++; $display("FAIL blink_off got=%b exp=0000", LED); end
  endtask

  task automatic test_burst();
    logic [3:0] exp;
    cfg_write(3'd1, 2'd3, 16'd1, 4'd2);
    for (int k = 0; k < 16; k++) begin
      next_tick_edge();
      exp = 4'b0000;
      exp[1] = ((k % 8) == 0) || ((k % 8) == 2);
      n_cmp++;
      if (LED !== exp) begin n_err++; $display("FAIL burst_tick%0d got=%b exp=%b", k, LED, exp); end
    end
  endtask

  task automatic test_handshake();
    int   n;
    logic exp_rdy, exp2, exp3;
    n = 0;
    while ((cyc % 10) != 2 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    for (int r = 0; r <= 40; r++) begin
      exp_rdy = (r == 0) || (r == 9) || (r >= 19);
      exp2    = (r >= 9);
      exp3    = (r >= 19 && r < 29) || (r >= 39);
      n_cmp++;
      if (CFG_READY !== exp_rdy) begin n_err++; $display("FAIL hs_ready_r%0d got=%b exp=%b", r, CFG_READY, exp_rdy); end
      n_cmp++;
      if (LED[2] !== exp2) begin n_err++; $display("FAIL hs_led2_r%0d got=%b exp=%b", r, LED[2], exp2); end
      n_cmp++;
      if (LED[3] !== exp3) begin n_err++; $display("FAIL hs_led3_r%0d got=%b exp=%b", r, LED[3], exp3); end
      @(negedge CLK);
      CFG_VALID = (r <= 14);
      if (r == 0) begin
        CFG_CH = 3'd2; CFG_MODE = 2'd1; CFG_HALF = 16'd5; CFG_COUNT = 4'd0;
      end else begin
        CFG_CH = 3'd3; CFG_MODE = 2'd2; CFG_HALF = 16'd1; CFG_COUNT = 4'd0;
      end
      @(posedge CLK); #1;
    end
    CFG_VALID = 1'b0;
  endtask

  task automatic test_edge_fields();
    logic exp;
    cfg_write(3'd0, 2'd2, 16'd0, 4'd0);
    for (int k = 0; k < 6; k++) begin
      next_tick_edge();
      exp = (k % 2 == 0);
      n_cmp++;
      if (LED[0] !== exp) begin n_err++; $display("FAIL half0_tick%0d got=%b exp=%b", k, LED[0], exp); end
    end
    cfg_write(3'd2, 2'd3, 16'd2, 4'd0);
    for (int k = 0; k < 6; k++) begin
      next_tick_edge();
      n_cmp++;
      if (LED[2] !== 1'b0) begin n_err++; $display("FAIL count0_tick%0d got=%b exp=0", k, LED[2]); end
    end
    cfg_write(3'd0, 2'd0, 16'd0, 4'd0); next_tick_edge();
    cfg_write(3'd1, 2'd0, 16'd0, 4'd0); next_tick_edge();
    cfg_write(3'd3, 2'd0, 16'd0, 4'd0); next_tick_edge();
    n_cmp++; if (LED !== 4'b0000) begin n_err++; $display("FAIL all_off got=%b exp=0000", LED); end
    cfg_write(3'd5, 2'd1, 16'd1, 4'd0);
    n_cmp++; if (CFG_READY !== 1'b0) begin n_err++; $display("FAIL badch_accept ready=%b exp=0", CFG_READY); end
    for (int k = 0; k < 4; k++) begin
      next_tick_edge();
      n_cmp++;
      if (LED !== 4'b0000) begin n_err++; $display("FAIL badch_tick%0d got=%b exp=0000", k, LED); end
    end
    n_cmp++; if (CFG_READY !== 1'b1) begin n_err++; $display("FAIL badch_ready got=%b exp=1", CFG_READY); end
  endtask

  task automatic test_reset_mid_burst();
    cfg_write(3'd1, 2'd3, 16'd1, 4'd2);
    next_tick_edge();
    n_cmp++; if (LED !== 4'b0010) begin n_err++; $display("FAIL rb_start got=%b exp=0010", LED); end
    repeat (5) next_tick_edge();
    n_cmp++; if (LED !== 4'b0000) begin n_err++; $display("FAIL rb_gap got=%b exp=0000", LED); end
    cfg_write(3'd0, 2'd1, 16'd1, 4'd0);
    n_cmp++; if (CFG_READY !== 1'b0) begin n_err++; $display("FAIL rb_pending ready=%b exp=0", CFG_READY); end
    #2;
    RESETN = 1'b0;
    #1;
    n_cmp++; if (LED !== 4'b0000) begin n_err++; $display("FAIL rb_async_led got=%b exp=0000", LED); end
    n_cmp++; if (CFG_READY !== 1'b1) begin n_err++; $display("FAIL rb_async_ready got=%b exp=1", CFG_READY); end
    n_cmp++; if (TICK !== 1'b0) begin n_err++; $display("FAIL rb_async_tick got=%b exp=0", TICK); end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESETN = 1'b1;
    for (int k = 0; k < 12; k++) begin
      next_tick_edge();
      n_cmp++;
      if (LED !== 4'b0000) begin n_err++; $display("FAIL rb_idle_tick%0d got=%b exp=0000", k, LED); end
    end
    cfg_write(3'd1, 2'd1, 16'd1, 4'd0);
    next_tick_edge();
    n_cmp++; if (LED !== 4'b0010) begin n_err++; $display("FAIL rb_reconfig got=%b exp=0010", LED); end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_burst();
    test_handshake();
    test_edge_fields();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
